// File: rtl/servo_pkg.sv
// Shared constants, pulse-width type and position-to-width mapping for the
// servo PWM generator.
package servo_pkg;

  // Pulse widths, active/target values and counter comparisons are 32-bit unsigned.
  typedef logic [31:0] pulse_t;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_POS_W    = 8;

  // 50 Hz frame length in clock ticks.
  function automatic int unsigned period_ticks_of(input int unsigned clk_freq);
    return clk_freq / 50;
  endfunction

  // 1.0 ms pulse at position 0.
  function automatic int unsigned min_pulse_of(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  // 2.0 ms nominal full-scale pulse.
  function automatic int unsigned max_pulse_of(input int unsigned clk_freq);
    return clk_freq / 500;
  endfunction

  // Integer ticks per position LSB; the remainder is dropped, so full scale
  // lands slightly below max_pulse and never needs clamping.
  function automatic int unsigned lsb_ticks_of(input int unsigned min_ticks,
                                               input int unsigned max_ticks,
                                               input int unsigned pos_w);
    return (max_ticks - min_ticks) / ((32'd1 << pos_w) - 32'd1);
  endfunction

  // Position to pulse width: one constant multiply and an add, no divider.
  function automatic pulse_t map_pos(input pulse_t pos,
                                     input pulse_t min_ticks,
                                     input pulse_t ticks_per_lsb);
    return min_ticks + pos * ticks_per_lsb;
  endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// One slew step of the active pulse width toward the target width.
// Saturates at the target and never wraps below zero or above 2**32-1.
module pwm_slew_step
  import servo_pkg::*;
(
  input  pulse_t active,
  input  pulse_t target,
  input  pulse_t slew_ticks,
  output pulse_t next_active
);

  // Move at most slew_ticks toward target; a zero limit means jump directly.
  // Distances are compared before any add/subtract so neither direction can
  // overflow or underflow.
  always_comb begin
    next_active = target;
    if (slew_ticks != '0) begin
      if (active < target) begin
        if ((target - active) > slew_ticks) next_active = active + slew_ticks;
      end else if ((active - target) > slew_ticks) begin
        next_active = active - slew_ticks;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM channel: accepts position commands over valid/ready, holds one
// pending command, and applies it only at a period boundary with slew
// limiting, so no pulse is ever truncated or doubled.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = DEF_CLK_FREQ,
  parameter int unsigned PERIOD_TICKS    = period_ticks_of(CLK_FREQ),
  parameter int unsigned MIN_PULSE_TICKS = min_pulse_of(CLK_FREQ),
  parameter int unsigned MAX_PULSE_TICKS = max_pulse_of(CLK_FREQ),
  parameter int unsigned POS_W           = DEF_POS_W,
  parameter int unsigned TICKS_PER_LSB   = lsb_ticks_of(MIN_PULSE_TICKS, MAX_PULSE_TICKS, POS_W),
  parameter int unsigned SLEW_TICKS      = 2000,
  parameter int unsigned RESET_POS       = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      counter_in,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] pos_data,
  output logic             pos_ready,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             at_target
);

  localparam pulse_t RESET_WIDTH = map_pos(pulse_t'(RESET_POS), pulse_t'(MIN_PULSE_TICKS),
                                           pulse_t'(TICKS_PER_LSB));
  localparam pulse_t FULL_WIDTH  = map_pos(pulse_t'((32'd1 << POS_W) - 32'd1),
                                           pulse_t'(MIN_PULSE_TICKS), pulse_t'(TICKS_PER_LSB));
  localparam pulse_t LAST_TICK   = pulse_t'(PERIOD_TICKS - 1);

  // Full-scale pulse must fit inside the nominal maximum and inside the frame.
  if (FULL_WIDTH > pulse_t'(MAX_PULSE_TICKS) || MAX_PULSE_TICKS >= PERIOD_TICKS) begin : g_param_check
    $error("servo_pwm_gen: full-scale pulse exceeds MAX_PULSE_TICKS or the frame");
  end

  logic [POS_W-1:0] pending_q, pending_d;
  logic             pending_full_q, pending_full_d;
  logic             pos_ready_q, pos_ready_d;
  pulse_t           target_q, target_d;
  pulse_t           active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             period_tick_q, period_tick_d;
  logic             at_target_q, at_target_d;

  logic             boundary;
  logic             accept;
  pulse_t           next_target;
  pulse_t           slewed;

  // Decode the boundary cycle, the handshake, and the width to chase next.
  always_comb begin
    boundary    = (counter_in == LAST_TICK);
    accept      = pos_valid && pos_ready_q;
    next_target = pending_full_q
                ? map_pos(pulse_t'(pending_q), pulse_t'(MIN_PULSE_TICKS), pulse_t'(TICKS_PER_LSB))
                : target_q;
  end

  pwm_slew_step u_slew_step (
    .active      (active_q),
    .target      (next_target),
    .slew_ticks  (pulse_t'(SLEW_TICKS)),
    .next_active (slewed)
  );

  // Next-state logic: boundary updates first, then a same-cycle accept refills
  // the slot so a command taken on the boundary applies one frame later.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    target_d       = target_q;
    active_d       = active_q;
    if (boundary) begin
      pending_full_d = 1'b0;
      target_d       = next_target;
      active_d       = slewed;
    end
    if (accept) begin
      pending_d      = pos_data;
      pending_full_d = 1'b1;
    end
    pos_ready_d   = !pending_full_d;
    pwm_d         = (counter_in < active_q);
    period_tick_d = boundary;
    at_target_d   = (active_d == target_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge like any other input, so a
    // mid-frame reset cuts the pulse on the very next edge.
    if (rst) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of its neighbours.
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pos_ready_q    <= 1'b1;
      target_q       <= RESET_WIDTH;
      active_q       <= RESET_WIDTH;
      pwm_q          <= 1'b0;
      period_tick_q  <= 1'b0;
      at_target_q    <= 1'b1;
    end else begin
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pos_ready_q    <= pos_ready_d;
      target_q       <= target_d;
      active_q       <= active_d;
      pwm_q          <= pwm_d;
      period_tick_q  <= period_tick_d;
      at_target_q    <= at_target_d;
    end
  end

  assign pos_ready   = pos_ready_q;
  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;
  assign at_target   = at_target_q;

endmodule
